// File: rtl/instrumented_adder_meas_ctrl.sv
// Measurement sequencer for the instrumented ripple adder.
//
// A start request latches the operand and bit-select configuration straight into the
// registers that drive the adder, so the adder inputs stay static from SETUP until the
// next start. After a settle interval, the sequencer counts rising edges of the
// asynchronous chain_out over a programmable window. It then captures the edge count
// and the adder sum, and signals completion with a busy/done handshake.
//
// Ports:
//   wb_clk_i, wb_rst_i     clock, asynchronous active-high reset
//   start, abort           single-cycle run request / cancel of the run in progress
//   cfg_a, cfg_b           operands
//   cfg_ext_sel            external-drive bit select
//   cfg_ring_sel           ring-drive bit select
//   cfg_sum_sel            sum-output tap bit select
//   cfg_window             count window length in cycles (0 skips counting)
//   adder_sum              adder sum output, captured at the end of a run
//   chain_out              ring/chain output, asynchronous to wb_clk_i
//   adder_*                operand and bit-select buses to the adder
//   ring_en                ring loop enable (SETTLE and MEASURE)
//   busy, done             run in progress / results valid (sticky until next start)
//   edge_count             captured rising-edge count
//   sum_result             captured adder sum
//   overflow               edge counter saturated during the last captured run
module instrumented_adder_meas_ctrl #(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned WIN_W         = 16,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cfg_a,
  input  logic [WIDTH-1:0] cfg_b,
  input  logic [WIDTH-1:0] cfg_ext_sel,
  input  logic [WIDTH-1:0] cfg_ring_sel,
  input  logic [WIDTH-1:0] cfg_sum_sel,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             chain_out,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic [WIDTH-1:0] adder_ext_bit_b,
  output logic [WIDTH-1:0] adder_ring_bit_b,
  output logic [WIDTH-1:0] adder_s_bit_b,
  output logic             ring_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_count,
  output logic [WIDTH-1:0] sum_result,
  output logic             overflow
);

  localparam int unsigned SetW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned TmrW = (WIN_W > SetW) ? WIN_W : SetW;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StSettle,
    StMeasure,
    StCapture,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [WIN_W-1:0]  window_q;
  logic [WIDTH-1:0]  a_q, b_q, ext_q, ring_q, sum_sel_q;

  logic              sync1_q, sync2_q, sync3_q;
  logic              rise;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [CNT_W-1:0]  edge_count_q;
  logic [WIDTH-1:0]  sum_result_q;
  logic              overflow_q;

  logic              load_cfg;
  logic              clr_cnt;
  logic              count_en;
  logic              capture;

  // Next-state and control strobes. abort wins over start in every state.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    load_cfg = 1'b0;
    clr_cnt  = 1'b0;
    count_en = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          load_cfg = 1'b1;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          clr_cnt = 1'b1;
          tmr_d   = TmrW'(SETTLE_CYCLES - 1);
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (abort) begin
          state_d = StIdle;
        end else if (tmr_q == '0) begin
          if (window_q == '0) begin
            state_d = StCapture;
          end else begin
            tmr_d   = TmrW'(window_q) - TmrW'(1);
            state_d = StMeasure;
          end
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      StMeasure: begin
        count_en = 1'b1;
        if (abort) begin
          state_d = StIdle;
        end else if (tmr_q == '0) begin
          state_d = StCapture;
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      StCapture: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          capture = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (abort) begin
          state_d = StIdle;
        end else if (start) begin
          load_cfg = 1'b1;
          state_d  = StSetup;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Rising edge of the synchronised chain output.
  assign rise = sync2_q & ~sync3_q;

  // Saturating live edge counter; overflow marks the first increment lost at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_cnt) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (count_en && rise) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sync1_q <= chain_out;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // The configuration is latched directly into the adder drive registers. They are
  // visible from the SETUP cycle on and hold through CAPTURE, DONE and abort.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      window_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      ext_q     <= '0;
      ring_q    <= '0;
      sum_sel_q <= '0;
    end else if (load_cfg) begin
      window_q  <= cfg_window;
      a_q       <= cfg_a;
      b_q       <= cfg_b;
      ext_q     <= cfg_ext_sel;
      ring_q    <= cfg_ring_sel;
      sum_sel_q <= cfg_sum_sel;
    end
  end

  // Results change only on a completed CAPTURE, so an aborted run leaves them intact.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      edge_count_q <= '0;
      sum_result_q <= '0;
      overflow_q   <= 1'b0;
    end else if (capture) begin
      edge_count_q <= cnt_q;
      sum_result_q <= adder_sum;
      overflow_q   <= ovf_q;
    end
  end

  assign adder_a          = a_q;
  assign adder_b          = b_q;
  assign adder_ext_bit_b  = ext_q;
  assign adder_ring_bit_b = ring_q;
  assign adder_s_bit_b    = sum_sel_q;

  // Decoded from the state register so that an asynchronous reset drops ring_en at once.
  assign ring_en = (state_q == StSettle) || (state_q == StMeasure);
  assign busy    = (state_q == StSetup) || (state_q == StSettle) ||
                   (state_q == StMeasure) || (state_q == StCapture);
  assign done    = (state_q == StDone);

  assign edge_count = edge_count_q;
  assign sum_result = sum_result_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_instrumented_adder_meas_ctrl.sv
// Self-checking bench for instrumented_adder_meas_ctrl. Inputs are driven on the falling
// edge and outputs are sampled there too. chain_out and adder_sum are recorded at every
// rising edge, so the expected edge count and captured sum are derived from the recorded
// history and the run timeline.
module tb_instrumented_adder_meas_ctrl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int WIN_W = 16;
  localparam int S     = 4;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WIDTH-1:0] cfg_a = '0, cfg_b = '0, cfg_ext_sel = '0, cfg_ring_sel = '0;
  logic [WIDTH-1:0] cfg_sum_sel = '0;
  logic [WIN_W-1:0] cfg_window = '0;
  logic [WIDTH-1:0] adder_sum = '0;
  logic             chain_out = 1'b0;
  logic [WIDTH-1:0] adder_a, adder_b, adder_ext_bit_b, adder_ring_bit_b, adder_s_bit_b;
  logic             ring_en, busy, done, overflow;
  logic [CNT_W-1:0] edge_count;
  logic [WIDTH-1:0] sum_result;

  instrumented_adder_meas_ctrl #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYCLES(S)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .abort(abort),
    .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_ext_sel(cfg_ext_sel), .cfg_ring_sel(cfg_ring_sel),
    .cfg_sum_sel(cfg_sum_sel), .cfg_window(cfg_window), .adder_sum(adder_sum),
    .chain_out(chain_out), .adder_a(adder_a), .adder_b(adder_b),
    .adder_ext_bit_b(adder_ext_bit_b), .adder_ring_bit_b(adder_ring_bit_b),
    .adder_s_bit_b(adder_s_bit_b), .ring_en(ring_en), .busy(busy), .done(done),
    .edge_count(edge_count), .sum_result(sum_result), .overflow(overflow)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Input history as seen by the DUT at each rising edge.
  logic        smp[$];
  logic [31:0] sumrec[$];
  int          ecnt = 0;

  always @(posedge wb_clk_i) begin
    smp.push_back(chain_out);
    sumrec.push_back(adder_sum);
    ecnt++;
  end

  // chain_out pattern: 0 hold, >0 toggle every hp cycles, <0 random level each cycle.
  int hp = 0;
  int ph = 0;
  always @(negedge wb_clk_i) begin
    adder_sum = $urandom;
    if (hp < 0) begin
      chain_out = 1'($urandom_range(1, 0));
    end else if (hp > 0) begin
      ph++;
      if (ph >= hp) begin
        ph = 0;
        chain_out = ~chain_out;
      end
    end
  end

  // Results of the last completed capture.
  logic [CNT_W-1:0] prev_ec = '0;
  logic [31:0]      prev_sum = '0;
  logic             prev_ov = 1'b0;

  // Counted edges: cycles after edges e0+S+1 .. e0+S+win are MEASURE; during the cycle
  // after edge t the synchroniser holds the levels sampled at edges t-1 and t-2.
  function automatic int true_edges(input int e0, input int win);
    int c = 0;
    for (int t = e0 + S + 1; t <= e0 + S + win; t++) begin
      if (smp[t-1] === 1'b1 && smp[t-2] === 1'b0) c++;
    end
    return c;
  endfunction

  task automatic run_meas(input int win, input int abort_k, input int glitch_k,
                          input bit fixed);
    logic [31:0] a, b, ex, rg, sm;
    int          e0, last, ring_cnt, tc, cmax;
    bit          aborted;
    a  = fixed ? 32'd3 : $urandom;
    b  = fixed ? 32'd5 : $urandom;
    ex = fixed ? 32'd0 : $urandom;
    rg = fixed ? 32'h4 : $urandom;
    sm = $urandom;
    @(negedge wb_clk_i);
    cfg_a = a; cfg_b = b; cfg_ext_sel = ex; cfg_ring_sel = rg; cfg_sum_sel = sm;
    cfg_window = 16'(win);
    start = 1'b1;
    e0 = ecnt;
    last = S + win + 3;
    ring_cnt = 0;
    aborted = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(negedge wb_clk_i);
      start = 1'b0;
      abort = 1'b0;
      if (k == 1) begin
        // New cfg values must not leak into the latched configuration.
        cfg_a = $urandom; cfg_b = $urandom; cfg_ring_sel = $urandom;
        cfg_window = 16'($urandom_range(200, 0));
      end
      if (abort_k != 0 && k == abort_k + 1) begin
        check_val("abort_ring_en", 64'(ring_en), 64'd0);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_done", 64'(done), 64'd0);
        check_val("abort_edge_count", 64'(edge_count), 64'(prev_ec));
        check_val("abort_sum_result", 64'(sum_result), 64'(prev_sum));
        check_val("abort_adder_a", 64'(adder_a), 64'(a));
        aborted = 1'b1;
        break;
      end
      check_val("ring_en", 64'(ring_en), 64'((k >= 2) && (k <= S + 1 + win)));
      check_val("busy", 64'(busy), 64'(k <= S + win + 2));
      check_val("done", 64'(done), 64'(k >= S + win + 3));
      ring_cnt += int'(ring_en);
      if (k == 1 || k == last) begin
        check_val("adder_a", 64'(adder_a), 64'(a));
        check_val("adder_b", 64'(adder_b), 64'(b));
        check_val("adder_ext", 64'(adder_ext_bit_b), 64'(ex));
        check_val("adder_ring", 64'(adder_ring_bit_b), 64'(rg));
        check_val("adder_s", 64'(adder_s_bit_b), 64'(sm));
      end
      if (k == abort_k) abort = 1'b1;
      if (k == glitch_k) start = 1'b1;
    end
    if (!aborted) begin
      tc   = true_edges(e0, win);
      cmax = (1 << CNT_W) - 1;
      check_val("ring_cycles", 64'(ring_cnt), 64'(S + win));
      check_val("edge_count", 64'(edge_count), 64'((tc > cmax) ? cmax : tc));
      check_val("overflow", 64'(overflow), 64'(tc > cmax));
      check_val("sum_result", 64'(sum_result), 64'(sumrec[e0 + S + win + 2]));
      prev_ec  = edge_count;
      prev_sum = sum_result;
      prev_ov  = overflow;
    end
  endtask

  initial begin
    repeat (3) @(negedge wb_clk_i);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_ring_en", 64'(ring_en), 64'd0);
    check_val("rst_adder_a", 64'(adder_a), 64'd0);
    check_val("rst_edge_count", 64'(edge_count), 64'd0);
    check_val("rst_overflow", 64'(overflow), 64'd0);
    wb_rst_i = 1'b0;
    hp = 4;
    repeat (4) @(negedge wb_clk_i);

    run_meas(10, 0, 0, 1'b1);
    hp = 3;
    run_meas(0, 0, 0, 1'b0);
    hp = 2;
    run_meas(100, 0, 0, 1'b0);
    check_val("sat_count", 64'(edge_count), 64'd15);
    check_val("sat_overflow", 64'(overflow), 64'd1);
    run_meas(4, 0, 0, 1'b0);
    check_val("ovf_cleared", 64'(overflow), 64'd0);

    hp = 4;
    run_meas(28, 0, 0, 1'b0);
    run_meas(20, S + 3, 0, 1'b0);
    run_meas(8, 0, 3, 1'b0);
    run_meas(6, 0, 0, 1'b0);

    // abort and start together while DONE: back to IDLE, no new run.
    start = 1'b1;
    abort = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    abort = 1'b0;
    check_val("abst_done", 64'(done), 64'd0);
    check_val("abst_busy", 64'(busy), 64'd0);
    @(negedge wb_clk_i);
    check_val("abst_idle", 64'(busy), 64'd0);
    check_val("abst_count", 64'(edge_count), 64'(prev_ec));

    for (int i = 0; i < 6; i++) begin
      hp = (i % 2 == 0) ? -1 : $urandom_range(5, 1);
      run_meas($urandom_range(24, 0), 0, 0, 1'b0);
    end

    // Reset between clock edges during MEASURE.
    hp = 2;
    @(negedge wb_clk_i);
    cfg_a = $urandom; cfg_ring_sel = 32'hffff; cfg_window = 16'd20;
    start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    repeat (S + 2) @(negedge wb_clk_i);
    check_val("pre_rst_ring_en", 64'(ring_en), 64'd1);
    @(posedge wb_clk_i);
    #3 wb_rst_i = 1'b1;
    #1;
    check_val("mid_rst_ring_en", 64'(ring_en), 64'd0);
    check_val("mid_rst_busy", 64'(busy), 64'd0);
    check_val("mid_rst_adder_ring", 64'(adder_ring_bit_b), 64'd0);
    check_val("mid_rst_edge_count", 64'(edge_count), 64'd0);
    check_val("mid_rst_sum", 64'(sum_result), 64'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    prev_ec = '0; prev_sum = '0; prev_ov = 1'b0;
    repeat (4) @(negedge wb_clk_i);
    run_meas(12, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
